// File: rtl/grinch_pkg.sv
// Shared VGA timing defaults, entity codes and the 12-bit colour palette for the snake display.
// The palette lives here so that the game logic and the renderer agree on what each code means.
package grinch_pkg;

    localparam int H_VISIBLE_DEF       = 640;
    localparam int H_FRONT_DEF         = 16;
    localparam int H_SYNC_DEF          = 96;
    localparam int H_BACK_DEF          = 48;
    localparam int V_VISIBLE_DEF       = 480;
    localparam int V_FRONT_DEF         = 10;
    localparam int V_SYNC_DEF          = 2;
    localparam int V_BACK_DEF          = 33;
    localparam int FRAMES_PER_TICK_DEF = 8;

    localparam int X_W = 10;
    localparam int Y_W = 9;

    typedef enum logic [1:0] {
        FRUIT = 2'b00,
        HEAD  = 2'b01,
        TAIL  = 2'b10,
        EMPTY = 2'b11
    } entity_t;

    typedef logic [11:0] rgb12_t;

    localparam rgb12_t RGB_BLACK = 12'h000;
    localparam rgb12_t RGB_HEAD  = 12'h0F0;
    localparam rgb12_t RGB_FRUIT = 12'hF00;
    localparam rgb12_t RGB_TAIL  = 12'h080;
    localparam rgb12_t RGB_OVER  = 12'h400;
    localparam rgb12_t RGB_WON   = 12'h00F;

    // Background tint: a won game outranks a lost one.
    function automatic rgb12_t entity_colour(input entity_t e, input logic won, input logic over);
        rgb12_t c;
        c = RGB_BLACK;
        case (e)
            HEAD:    c = RGB_HEAD;
            FRUIT:   c = RGB_FRUIT;
            TAIL:    c = RGB_TAIL;
            EMPTY:   c = won ? RGB_WON : (over ? RGB_OVER : RGB_BLACK);
            default: c = RGB_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Free-running h/v raster counters with stage-0 sync, visible and pixel-coordinate outputs.
// Zero latency from counters to outputs; no backpressure, the raster never stalls.
module vga_timing
    import grinch_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF
) (
    input  logic           clk_i,
    input  logic           reset_i,
    output logic [X_W-1:0] x_o,
    output logic [Y_W-1:0] y_o,
    output logic           visible_o,
    output logic           hsync_o,
    output logic           vsync_o,
    output logic           frame_pos_o
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS_C  = HW'(H_VISIBLE);
    localparam logic [HW-1:0] HS_START = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] HS_END   = HW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS_C  = VW'(V_VISIBLE);
    localparam logic [VW-1:0] VS_START = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] VS_END   = VW'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic          h_vis, v_vis;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    always_comb begin
        h_cnt_d = h_cnt_q + HW'(1);
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
        end
    end

    // Coordinates read as zero in blanking so the game logic never sees off-screen positions.
    always_comb begin
        h_vis       = (h_cnt_q < H_VIS_C);
        v_vis       = (v_cnt_q < V_VIS_C);
        visible_o   = h_vis && v_vis;
        x_o         = h_vis ? X_W'(h_cnt_q) : '0;
        y_o         = v_vis ? Y_W'(v_cnt_q) : '0;
        hsync_o     = !((h_cnt_q >= HS_START) && (h_cnt_q <= HS_END));
        vsync_o     = !((v_cnt_q >= VS_START) && (v_cnt_q <= VS_END));
        frame_pos_o = (h_cnt_q == '0) && (v_cnt_q == V_VIS_C);
    end

endmodule

// File: rtl/vga_renderer.sv
// VGA renderer: raster timing, 2-stage sync/colour pipeline (counters to pins = 2 clks), game-rate tick.
// Free-running with no handshake; entity is trusted to arrive exactly 1 clk after x_out/y_out.
module vga_renderer
    import grinch_pkg::*;
#(
    parameter int H_VISIBLE       = H_VISIBLE_DEF,
    parameter int H_FRONT         = H_FRONT_DEF,
    parameter int H_SYNC          = H_SYNC_DEF,
    parameter int H_BACK          = H_BACK_DEF,
    parameter int V_VISIBLE       = V_VISIBLE_DEF,
    parameter int V_FRONT         = V_FRONT_DEF,
    parameter int V_SYNC          = V_SYNC_DEF,
    parameter int V_BACK          = V_BACK_DEF,
    parameter int FRAMES_PER_TICK = FRAMES_PER_TICK_DEF
) (
    input  logic           vga_clk,
    input  logic           reset,
    input  logic [1:0]     entity,
    input  logic           game_over,
    input  logic           game_won,
    output logic [X_W-1:0] x_out,
    output logic [Y_W-1:0] y_out,
    output logic           hsync,
    output logic           vsync,
    output logic [3:0]     vga_r,
    output logic [3:0]     vga_g,
    output logic [3:0]     vga_b,
    output logic           update_tick
);

    localparam int FCW = (FRAMES_PER_TICK > 1) ? $clog2(FRAMES_PER_TICK) : 1;
    localparam logic [FCW-1:0] FC_LAST = FCW'(FRAMES_PER_TICK - 1);

    logic visible_0, hsync_0, vsync_0, frame_pos_0;

    logic           visible_1_q, visible_1_d;
    logic           hsync_1_q, hsync_1_d;
    logic           vsync_1_q, vsync_1_d;
    logic           hsync_q, hsync_d;
    logic           vsync_q, vsync_d;
    rgb12_t         rgb_q, rgb_d;
    logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
    logic           tick;

    vga_timing #(
        .H_VISIBLE (H_VISIBLE),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK)
    ) u_timing (
        .clk_i       (vga_clk),
        .reset_i     (reset),
        .x_o         (x_out),
        .y_o         (y_out),
        .visible_o   (visible_0),
        .hsync_o     (hsync_0),
        .vsync_o     (vsync_0),
        .frame_pos_o (frame_pos_0)
    );

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            visible_1_q <= 1'b0;
            hsync_1_q   <= 1'b1;
            vsync_1_q   <= 1'b1;
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
            rgb_q       <= RGB_BLACK;
            frame_cnt_q <= '0;
        end else begin
            visible_1_q <= visible_1_d;
            hsync_1_q   <= hsync_1_d;
            vsync_1_q   <= vsync_1_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            rgb_q       <= rgb_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Stage 1 holds the syncs level with the game logic's registered entity; stage 2 drives the pins.
    always_comb begin
        visible_1_d = visible_0;
        hsync_1_d   = hsync_0;
        vsync_1_d   = vsync_0;
        hsync_d     = hsync_1_q;
        vsync_d     = vsync_1_q;
        rgb_d       = visible_1_q ? entity_colour(entity_t'(entity), game_won, game_over) : RGB_BLACK;
    end

    // The divider steps on the first blanking line, so a tick can never tear a visible frame.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        tick        = 1'b0;
        if (frame_pos_0) begin
            if (frame_cnt_q == FC_LAST) begin
                frame_cnt_d = '0;
                tick        = 1'b1;
            end else begin
                frame_cnt_d = frame_cnt_q + FCW'(1);
            end
        end
        update_tick = tick && !reset;
    end

    assign hsync = hsync_q;
    assign vsync = vsync_q;
    assign vga_r = rgb_q[11:8];
    assign vga_g = rgb_q[7:4];
    assign vga_b = rgb_q[3:0];

endmodule

// File: tb/tb_vga_renderer.sv
// Bench: a full-size instance for line timing plus a shrunken raster instance for frame, colour, tick and reset checks.
module tb_vga_renderer;

    localparam int SH_VIS = 40, SH_FR = 4, SH_SY = 8, SH_BK = 4, SH_TOT = 56;
    localparam int SV_VIS = 8, SV_FR = 2, SV_SY = 2, SV_BK = 3, SV_TOT = 15;
    localparam int FPT    = 8;
    localparam int FRAME  = SH_TOT * SV_TOT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [1:0] entity;
    logic       game_over, game_won;

    logic [9:0] s_x, f_x;
    logic [8:0] s_y, f_y;
    logic       s_hs, s_vs, s_tick, f_hs, f_vs, f_tick;
    logic [3:0] s_r, s_g, s_b, f_r, f_g, f_b;
    logic [11:0] s_rgb, f_rgb;
    assign s_rgb = {s_r, s_g, s_b};
    assign f_rgb = {f_r, f_g, f_b};

    vga_renderer #(
        .H_VISIBLE(SH_VIS), .H_FRONT(SH_FR), .H_SYNC(SH_SY), .H_BACK(SH_BK),
        .V_VISIBLE(SV_VIS), .V_FRONT(SV_FR), .V_SYNC(SV_SY), .V_BACK(SV_BK),
        .FRAMES_PER_TICK(FPT)
    ) dut (
        .vga_clk(clk), .reset(reset), .entity(entity), .game_over(game_over), .game_won(game_won),
        .x_out(s_x), .y_out(s_y), .hsync(s_hs), .vsync(s_vs),
        .vga_r(s_r), .vga_g(s_g), .vga_b(s_b), .update_tick(s_tick)
    );

    vga_renderer dut_full (
        .vga_clk(clk), .reset(reset), .entity(entity), .game_over(game_over), .game_won(game_won),
        .x_out(f_x), .y_out(f_y), .hsync(f_hs), .vsync(f_vs),
        .vga_r(f_r), .vga_g(f_g), .vga_b(f_b), .update_tick(f_tick)
    );

    // Reference raster position of the shrunken instance.
    int ref_h, ref_v;
    always @(posedge clk) begin
        if (reset) begin
            ref_h <= 0;
            ref_v <= 0;
        end else if (ref_h == SH_TOT - 1) begin
            ref_h <= 0;
            ref_v <= (ref_v == SV_TOT - 1) ? 0 : ref_v + 1;
        end else begin
            ref_h <= ref_h + 1;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_pos(input int h, input int v, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (ref_h == h && ref_v == v) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    typedef struct {
        int          h;
        int          v;
        logic [1:0]  ent;
        logic        over;
        logic        won;
        logic [11:0] rgb;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int   fall1[3], fall2[3], rise1[3];
        logic prev[3], cur[3];
        int   max_x, max_y, n_ticks, tick_bad;
        int   tick_t[2];
        int   ex, ey;
        bit   ok;

        vecs[0]  = '{10, 2,  2'b01, 1'b0, 1'b0, 12'h0F0};
        vecs[1]  = '{14, 2,  2'b00, 1'b0, 1'b0, 12'hF00};
        vecs[2]  = '{18, 2,  2'b10, 1'b0, 1'b0, 12'h080};
        vecs[3]  = '{22, 2,  2'b11, 1'b0, 1'b0, 12'h000};
        vecs[4]  = '{26, 2,  2'b11, 1'b1, 1'b0, 12'h400};
        vecs[5]  = '{30, 2,  2'b11, 1'b1, 1'b1, 12'h00F};
        vecs[6]  = '{34, 2,  2'b11, 1'b0, 1'b1, 12'h00F};
        vecs[7]  = '{39, 3,  2'b01, 1'b0, 1'b0, 12'h0F0};
        vecs[8]  = '{45, 3,  2'b01, 1'b0, 1'b0, 12'h000};
        vecs[9]  = '{0,  7,  2'b10, 1'b0, 1'b0, 12'h080};
        vecs[10] = '{5,  8,  2'b01, 1'b0, 1'b0, 12'h000};
        vecs[11] = '{20, 12, 2'b11, 1'b1, 1'b1, 12'h000};
        vecs[12] = '{0,  0,  2'b00, 1'b0, 1'b0, 12'hF00};

        for (int i = 0; i < 3; i++) begin
            fall1[i] = -1; fall2[i] = -1; rise1[i] = -1; prev[i] = 1'b1;
        end
        max_x = 0; max_y = 0; n_ticks = 0; tick_bad = 0;
        tick_t[0] = -1; tick_t[1] = -1;

        reset = 1'b1; entity = 2'b00; game_over = 1'b0; game_won = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // 17 frames of the shrunken raster; the full-size instance runs alongside for line timing.
        for (int c = 0; c < 17 * FRAME; c++) begin
            @(negedge clk);
            cur[0] = f_hs; cur[1] = s_hs; cur[2] = s_vs;
            if (c == 0) begin
                check("rst_s_hsync", 32'(s_hs), 1);
                check("rst_s_vsync", 32'(s_vs), 1);
                check("rst_s_rgb", 32'(s_rgb), 0);
                check("rst_s_xy", {13'(s_x), 19'(s_y)}, 0);
                check("rst_f_sync", {30'(0), f_hs, f_vs}, 3);
                check("rst_f_rgb_xy", {f_rgb, f_x, 1'b0, f_y}, 0);
                check("rst_ticks", {30'(0), s_tick, f_tick}, 0);
            end
            for (int i = 0; i < 3; i++) begin
                if (prev[i] && !cur[i]) begin
                    if (fall1[i] < 0) fall1[i] = c;
                    else if (fall2[i] < 0) fall2[i] = c;
                end
                if (!prev[i] && cur[i] && rise1[i] < 0 && fall1[i] >= 0) rise1[i] = c;
                prev[i] = cur[i];
            end
            if (int'(s_x) > max_x) max_x = int'(s_x);
            if (int'(s_y) > max_y) max_y = int'(s_y);
            if (s_tick) begin
                if (n_ticks < 2) tick_t[n_ticks] = c;
                n_ticks++;
                if (!(ref_h == 0 && ref_v == SV_VIS)) tick_bad++;
            end
        end

        check("full_hsync_fall", fall1[0], 658);
        check("full_hsync_width", rise1[0] - fall1[0], 96);
        check("full_line_period", fall2[0] - fall1[0], 800);
        check("s_hsync_fall", fall1[1], SH_VIS + SH_FR + 2);
        check("s_hsync_width", rise1[1] - fall1[1], SH_SY);
        check("s_line_period", fall2[1] - fall1[1], SH_TOT);
        check("s_vsync_fall", fall1[2], (SV_VIS + SV_FR) * SH_TOT + 2);
        check("s_vsync_width", rise1[2] - fall1[2], SV_SY * SH_TOT);
        check("s_frame_period", fall2[2] - fall1[2], FRAME);
        check("s_x_max", max_x, SH_VIS - 1);
        check("s_y_max", max_y, SV_VIS - 1);
        check("tick_count", n_ticks, 2);
        check("tick_first", tick_t[0], SV_VIS * SH_TOT + (FPT - 1) * FRAME);
        check("tick_spacing", tick_t[1] - tick_t[0], FPT * FRAME);
        check("tick_position", tick_bad, 0);

        // Colour vectors: entity presented one clk after the coordinate, colour checked one clk later.
        for (int k = 0; k < 13; k++) begin
            wait_pos(vecs[k].h, vecs[k].v, ok);
            check($sformatf("vec%0d_found", k), 32'(ok), 1);
            if (ok) begin
                ex = (vecs[k].h < SH_VIS && vecs[k].v < SV_VIS) ? vecs[k].h : 0;
                ey = (vecs[k].v < SV_VIS) ? vecs[k].v : 0;
                if (vecs[k].h >= SH_VIS) ex = 0;
                else ex = vecs[k].h;
                check($sformatf("vec%0d_x", k), 32'(s_x), ex);
                check($sformatf("vec%0d_y", k), 32'(s_y), ey);
                game_over = vecs[k].over;
                game_won  = vecs[k].won;
                @(posedge clk);
                #1 entity = vecs[k].ent;
                @(posedge clk);
                @(negedge clk);
                check($sformatf("vec%0d_rgb", k), 32'(s_rgb), 32'(vecs[k].rgb));
            end
        end

        // One-clock reset mid-frame: raster restarts at (0,0) and the frame divider starts over.
        game_over = 1'b0; game_won = 1'b0;
        wait_pos(30, 5, ok);
        check("mid_reset_found", 32'(ok), 1);
        entity = 2'b01;
        reset  = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        n_ticks = 0; tick_t[0] = -1;
        for (int c = 0; c < 6400; c++) begin
            @(negedge clk);
            if (c == 0) begin
                check("mr_xy", {13'(s_x), 19'(s_y)}, 0);
                check("mr_sync", {30'(0), s_hs, s_vs}, 3);
                check("mr_rgb0", 32'(s_rgb), 0);
                check("mr_tick0", 32'(s_tick), 0);
            end
            if (c == 1) check("mr_rgb1", 32'(s_rgb), 0);
            if (c == 2) check("mr_rgb2", 32'(s_rgb), 32'h0F0);
            if (s_tick) begin
                if (n_ticks == 0) tick_t[0] = c;
                n_ticks++;
            end
        end
        check("mr_tick_count", n_ticks, 1);
        check("mr_tick_first", tick_t[0], SV_VIS * SH_TOT + (FPT - 1) * FRAME);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
